stage3_wb: RTL
==============

# stage3_wb

Write-back stage that terminates the execute-stage result path (`alu_out`, `wtsel`) and owns the architectural register file. It holds each incoming result one cycle, then commits it to a 32x32 register array. It also serves the two registered read ports (`rdata1`, `rdata2`) consumed by the execute stage, with full forwarding from both the incoming result and the held result. Register 0 is hardwired to zero.

## Interface
Parameters:
- `DW`, 32, data width
- `AW`, 5, register address width (2^AW registers)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `wb_valid`  in  1  `alu_out`/`wtsel` carry a result this cycle
- `alu_out`  in  DW  result from execute stage
- `wtsel`  in  AW  destination register of result
- `rs1`, `rs2`  in  AW  read selects
- `rd_en`  in  1  capture read data into `rdata1`/`rdata2` this edge
- `rdata1`, `rdata2`  out  DW  registered read data
- `pend_valid`  out  1  a held result awaits commit
- `wb_count`  out  16  count of committed writes, wraps

## Operation
- Hold register (`pend_valid`, `pend_sel`, `pend_data`): on each edge it loads `{wb_valid, wtsel, alu_out}`.
  - A hold with `wtsel==0` is still loaded. It is dropped at commit (no array write, no count).
- Commit: on each edge with `pend_valid=1` and `pend_sel!=0`, `regfile[pend_sel] <= pend_data` and `wb_count <= wb_count+1` (mod 2^16).
- Commit and a new hold load happen on the same edge. Back-to-back results stream at one per cycle with no stall.
- Read, per port `p` with select `rsp`, evaluated at an edge with `rd_en=1`, in priority order:
  1. `rsp==0` → 0
  2. `wb_valid & wtsel==rsp` → `alu_out` (incoming forward)
  3. `pend_valid & pend_sel==rsp` → `pend_data` (held forward)
  4. otherwise → `regfile[rsp]`
- With `rd_en=0`, `rdata1`/`rdata2` hold their value.
- Both ports may select the same register; both return the same value.
- Reset (async assert): `rdata1=rdata2=0`, `pend_valid=0`, `pend_sel=0`, `pend_data=0`, `wb_count=0`, all registers 0.
  - Reset mid-operation discards any held result; it is never committed.
  - Release is synchronous to `clk` by the surrounding design.

## Timing
- Result sampled at edge N is architecturally in `regfile` after edge N+1.
- A read at edge N, N+1 or later of that register returns the new value through the forwarding paths. Effective read-after-write latency is 0 cycles.
- `rdata*` are valid in the cycle after the `rd_en` edge; read latency is 1.
- `pend_valid` is asserted the cycle after `wb_valid`.
- `wb_count` increments the cycle after the commit edge.
- No combinational path from any input to any output.

## Structure
- Shared package `stage_pkg`: `DW`/`AW` defaults, `REG_ZERO` constant (5'd0), `wb_count` width constant.
- One sub-module, `regfile`: 2^AW x DW array with one synchronous write port (`we`, `wa`, `wd`), two combinational read ports, and async clear on `rst`.
  - `stage3_wb` holds the hold register, forwarding muxes, output registers and counter.

## Test plan
- Reset, then `rd_en=1` with `rs1=3`, `rs2=0` → `rdata1=0`, `rdata2=0`, `wb_count=0`, `pend_valid=0`.
- `wb_valid=1`, `wtsel=5`, `alu_out=32'hDEADBEEF` for one cycle, then read `rs1=5` two cycles later → `rdata1=32'hDEADBEEF`, `wb_count=1`.
- Same edge: `wb_valid=1`, `wtsel=7`, `alu_out=32'h11`, and `rd_en=1`, `rs1=rs2=7` → both `rdata` = 32'h11 next cycle (incoming forward).
- Write reg 9 = 32'hA, next cycle write reg 9 = 32'hB while reading `rs1=9` → `rdata1=32'hB`. Reading on the following edge also gives 32'hB (held forward beats the array).
- `wb_valid=1`, `wtsel=0`, `alu_out=32'hFFFF_FFFF` → reading `rs1=0` gives 0; `wb_count` unchanged.
- Write reg 4 = 32'h55, assert `rst` while `pend_valid=1`, release, read `rs1=4` → 0, `wb_count=0`.

Source files
------------

// File: rtl/stage_pkg.sv
// Shared constants for the pipeline back end: default datapath widths,
// the hardwired-zero register index and the commit counter width.
package stage_pkg;

    localparam int DEF_DW = 32;
    localparam int DEF_AW = 5;
    localparam int WBC_W  = 16;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : stage_pkg

// File: rtl/stage3_wb_regfile.sv
// Architectural register array: one synchronous write port, two
// combinational read ports, asynchronous clear on active-low reset.
// Index 0 is never written, so it always reads back as zero.
module regfile
    import stage_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2
);

    localparam int NREG = 1 << AW;

    logic [DW-1:0] r_mem [NREG];

    logic w_wr;
    assign w_wr = we && (wa != AW'(REG_ZERO));

    // Array storage: cleared on reset, one write per edge, reg 0 protected
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr) begin
            r_mem[wa] <= wd;
        end
    end

    assign rd1 = r_mem[ra1];
    assign rd2 = r_mem[ra2];

endmodule : regfile

// File: rtl/stage3_wb.sv
// Write-back stage: holds each execute result for one cycle, commits it to
// the register array on the following edge, and serves two registered read
// ports with forwarding from both the incoming and the held result.
//
// Handshake: wb_valid is a qualifier only (no ready, never stalls). A result
// is accepted on every edge where wb_valid=1; rd_en=1 on an edge captures
// read data that is visible on rdata1/rdata2 during the following cycle.
module stage3_wb
    import stage_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_valid,
    input  logic [DW-1:0]    alu_out,
    input  logic [AW-1:0]    wtsel,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    input  logic             rd_en,
    output logic [DW-1:0]    rdata1,
    output logic [DW-1:0]    rdata2,
    output logic             pend_valid,
    output logic [WBC_W-1:0] wb_count
);

    // Hold register: result waiting one cycle before commit
    logic             r_pend_valid;
    logic [AW-1:0]    r_pend_sel;
    logic [DW-1:0]    r_pend_data;

    logic [DW-1:0]    r_rdata1;
    logic [DW-1:0]    r_rdata2;
    logic [WBC_W-1:0] r_wb_count;

    logic             w_commit;
    logic [DW-1:0]    w_arr1;
    logic [DW-1:0]    w_arr2;
    logic [DW-1:0]    w_fwd1;
    logic [DW-1:0]    w_fwd2;

    // A held result aimed at register 0 is dropped here: no write, no count
    assign w_commit = r_pend_valid && (r_pend_sel != AW'(REG_ZERO));

    regfile #(
        .DW (DW),
        .AW (AW)
    ) u_regfile (
        .clk (clk),
        .rst (rst),
        .we  (w_commit),
        .wa  (r_pend_sel),
        .wd  (r_pend_data),
        .ra1 (rs1),
        .ra2 (rs2),
        .rd1 (w_arr1),
        .rd2 (w_arr2)
    );

    // Read source priority: zero reg, incoming result, held result, array
    function automatic logic [DW-1:0] read_sel(
        input logic [AW-1:0] sel,
        input logic [DW-1:0] arr
    );
        if (sel == AW'(REG_ZERO)) begin
            return '0;
        end else if (wb_valid && (wtsel == sel)) begin
            return alu_out;
        end else if (r_pend_valid && (r_pend_sel == sel)) begin
            return r_pend_data;
        end else begin
            return arr;
        end
    endfunction

    // Forwarding muxes for both read ports
    always_comb begin
        w_fwd1 = read_sel(rs1, w_arr1);
        w_fwd2 = read_sel(rs2, w_arr2);
    end

    // Hold register loads every edge; reset discards any pending result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend_valid <= 1'b0;
            r_pend_sel   <= '0;
            r_pend_data  <= '0;
        end else begin
            r_pend_valid <= wb_valid;
            r_pend_sel   <= wtsel;
            r_pend_data  <= alu_out;
        end
    end

    // Registered read ports, updated only on rd_en edges
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata1 <= '0;
            r_rdata2 <= '0;
        end else if (rd_en) begin
            r_rdata1 <= w_fwd1;
            r_rdata2 <= w_fwd2;
        end
    end

    // Committed-write counter, wraps naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_count <= '0;
        end else if (w_commit) begin
            r_wb_count <= r_wb_count + 1'b1;
        end
    end

    assign rdata1     = r_rdata1;
    assign rdata2     = r_rdata2;
    assign pend_valid = r_pend_valid;
    assign wb_count   = r_wb_count;

endmodule : stage3_wb
